// File: rtl/sram_fifo_ctrl.sv
// Synchronous FIFO controller driving a dual-port SRAM with 1-cycle read latency.
// Optional sticky overflow/underflow outputs are enabled by defining FIFO_ERR_FLAGS_EN.
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  ram_wr_en,
  output logic                  ram_rd_en,
  input  logic [DATA_WIDTH-1:0] ram_data_out
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam logic [ADDR_WIDTH:0]   CNT_FULL  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = (ADDR_WIDTH+1)'(1'b0);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = ADDR_WIDTH'(1'b0);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1'b1);

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  pop_valid_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign full_s  = (count_r == CNT_FULL);
  assign empty_s = (count_r == CNT_ZERO);

  // Accept decode: a full FIFO refuses push, an empty one refuses pop, reset refuses both.
  always_comb begin
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    if (rst) begin
      push_ok_s = 1'b0;
      pop_ok_s  = 1'b0;
    end else begin
      push_ok_s = push && !full_s;
      pop_ok_s  = pop && !empty_s;
    end
  end

  // Pointer, occupancy and read-valid state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      pop_valid_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      // Read data arrives one edge after the strobe, matching the SRAM latency.
      pop_valid_r <= pop_ok_s;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags for requests made against a full or empty FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push && full_s) begin
        overflow_r <= 1'b1;
      end
      if (pop && empty_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`endif

  assign pop_data    = ram_data_out;
  assign pop_valid   = pop_valid_r;
  assign full        = full_s;
  assign empty       = empty_s;
  assign count       = count_r;
  assign ram_data_in = push_data;
  assign ram_wr_addr = wr_ptr_r;
  assign ram_rd_addr = rd_ptr_r;
  assign ram_wr_en   = push_ok_s;
  assign ram_rd_en   = pop_ok_s;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Testbench for sram_fifo_ctrl: SRAM model plus a queue-based FIFO reference.
// Define FIFO_ERR_FLAGS_EN to also check the sticky overflow/underflow outputs.
module tb_sram_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       push;
  logic [7:0] push_data;
  logic       pop;
  logic [7:0] pop_data;
  logic       pop_valid;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic [7:0] ram_data_in;
  logic [3:0] ram_wr_addr;
  logic [3:0] ram_rd_addr;
  logic       ram_wr_en;
  logic       ram_rd_en;
  logic [7:0] ram_data_out;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  sram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
    .count(count), .ram_data_in(ram_data_in), .ram_wr_addr(ram_wr_addr),
    .ram_rd_addr(ram_rd_addr), .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
    .ram_data_out(ram_data_out)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Dual-port SRAM with registered read data.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_data_in;
    if (ram_rd_en) ram_data_out <= mem[ram_rd_addr];
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] q[$];
  int         wr_idx = 0;
  int         rd_idx = 0;
  logic       exp_pv = 1'b0;
  logic [7:0] exp_pd = 8'h00;
  logic       exp_ovf = 1'b0;
  logic       exp_unf = 1'b0;
  // Pre-edge expectations and samples of the combinational RAM strobes
  logic       e_wr_en, e_rd_en;
  int         e_wr_addr, e_rd_addr;
  logic       s_wr_en, s_rd_en;
  logic [3:0] s_wr_addr, s_rd_addr;
  logic [7:0] s_din;

  // One clock cycle: drive, sample strobes before the edge, advance the model after it.
  task automatic tick(input logic r_i, input logic p_i, input logic pp_i, input logic [7:0] d_i);
    int sz;
    rst = r_i; push = p_i; pop = pp_i; push_data = d_i;
    #1;
    s_wr_en = ram_wr_en; s_rd_en = ram_rd_en;
    s_wr_addr = ram_wr_addr; s_rd_addr = ram_rd_addr; s_din = ram_data_in;
    sz = q.size();
    e_wr_en = !r_i && p_i && (sz < 16);
    e_rd_en = !r_i && pp_i && (sz > 0);
    e_wr_addr = wr_idx;
    e_rd_addr = rd_idx;
    @(posedge clk);
    #1;
    if (r_i) begin
      q.delete();
      wr_idx = 0; rd_idx = 0; exp_pv = 1'b0;
      exp_ovf = 1'b0; exp_unf = 1'b0;
    end else begin
      if (p_i && sz == 16) exp_ovf = 1'b1;
      if (pp_i && sz == 0) exp_unf = 1'b1;
      exp_pv = e_rd_en;
      if (e_rd_en) begin
        exp_pd = q.pop_front();
        rd_idx = (rd_idx + 1) % 16;
      end
      if (e_wr_en) begin
        q.push_back(d_i);
        wr_idx = (wr_idx + 1) % 16;
      end
    end
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, 8'h55);
    checks++; if (s_wr_en !== 1'b0 || s_rd_en !== 1'b0) begin errors++;
      $display("FAIL reset_strobes: wr_en=%b rd_en=%b required 0 0", s_wr_en, s_rd_en); end
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++;
      $display("FAIL reset_flags: empty=%b full=%b required 1 0", empty, full); end
    checks++; if (count !== 5'd0) begin errors++;
      $display("FAIL reset_count: got %0d required 0", count); end
    checks++; if (pop_valid !== 1'b0) begin errors++;
      $display("FAIL reset_pop_valid: got %b required 0", pop_valid); end
  endtask

  task automatic test_single();
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 8'hAB);
    checks++; if (s_wr_en !== 1'b1 || s_wr_addr !== 4'd0) begin errors++;
      $display("FAIL single_write: wr_en=%b addr=%0d required 1 0", s_wr_en, s_wr_addr); end
    checks++; if (count !== 5'd1) begin errors++;
      $display("FAIL single_count1: got %0d required 1", count); end
    tick(1'b0, 1'b0, 1'b1, 8'h00);
    checks++; if (s_rd_en !== 1'b1 || s_rd_addr !== 4'd0) begin errors++;
      $display("FAIL single_read: rd_en=%b addr=%0d required 1 0", s_rd_en, s_rd_addr); end
    checks++; if (pop_valid !== 1'b1 || pop_data !== 8'hAB) begin errors++;
      $display("FAIL single_data: valid=%b data=%h required 1 ab", pop_valid, pop_data); end
    checks++; if (count !== 5'd0) begin errors++;
      $display("FAIL single_count0: got %0d required 0", count); end
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (pop_valid !== 1'b0) begin errors++;
      $display("FAIL single_valid_drop: got %b required 0", pop_valid); end
  endtask

  task automatic test_fill_overflow();
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b1, 1'b0, 8'(i));
      checks++; if (s_wr_addr !== 4'(i) || s_wr_en !== 1'b1) begin errors++;
        $display("FAIL fill_addr: addr=%0d en=%b required %0d 1", s_wr_addr, s_wr_en, i); end
    end
    checks++; if (full !== 1'b1 || count !== 5'd16) begin errors++;
      $display("FAIL fill_full: full=%b count=%0d required 1 16", full, count); end
    tick(1'b0, 1'b1, 1'b0, 8'hFF);
    checks++; if (s_wr_en !== 1'b0 || count !== 5'd16 || full !== 1'b1) begin errors++;
      $display("FAIL overflow_push: wr_en=%b count=%0d full=%b required 0 16 1", s_wr_en, count, full); end
`ifdef FIFO_ERR_FLAGS_EN
    checks++; if (overflow !== 1'b1 || underflow !== 1'b0) begin errors++;
      $display("FAIL overflow_flag: ovf=%b unf=%b required 1 0", overflow, underflow); end
`endif
  endtask

  task automatic test_drain_underflow();
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b0, 1'b1, 8'h00);
      checks++; if (pop_valid !== 1'b1 || pop_data !== 8'(i)) begin errors++;
        $display("FAIL drain_data: valid=%b data=%h required 1 %h", pop_valid, pop_data, 8'(i)); end
    end
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin errors++;
      $display("FAIL drain_empty: empty=%b count=%0d required 1 0", empty, count); end
    tick(1'b0, 1'b0, 1'b1, 8'h00);
    checks++; if (s_rd_en !== 1'b0 || pop_valid !== 1'b0) begin errors++;
      $display("FAIL underflow_pop: rd_en=%b valid=%b required 0 0", s_rd_en, pop_valid); end
`ifdef FIFO_ERR_FLAGS_EN
    checks++; if (underflow !== 1'b1 || overflow !== 1'b1) begin errors++;
      $display("FAIL underflow_flag: unf=%b ovf=%b required 1 1", underflow, overflow); end
`endif
  endtask

  task automatic test_wrap();
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 8'h80);
    for (int i = 1; i < 16; i++) tick(1'b0, 1'b1, 1'b1, 8'h80 + 8'(i));
    checks++; if (count !== 5'd1 || pop_data !== 8'h8E) begin errors++;
      $display("FAIL wrap_setup: count=%0d data=%h required 1 8e", count, pop_data); end
    tick(1'b0, 1'b1, 1'b1, 8'hC0);
    checks++; if (s_wr_en !== 1'b1 || s_rd_en !== 1'b1 || s_wr_addr !== 4'd0 || s_rd_addr !== 4'd15) begin errors++;
      $display("FAIL wrap_strobes: wr=%b rd=%b waddr=%0d raddr=%0d required 1 1 0 15", s_wr_en, s_rd_en, s_wr_addr, s_rd_addr); end
    checks++; if (count !== 5'd1 || pop_valid !== 1'b1 || pop_data !== 8'h8F) begin errors++;
      $display("FAIL wrap_data15: count=%0d valid=%b data=%h required 1 1 8f", count, pop_valid, pop_data); end
    tick(1'b0, 1'b0, 1'b1, 8'h00);
    checks++; if (s_rd_addr !== 4'd0 || pop_data !== 8'hC0 || empty !== 1'b1) begin errors++;
      $display("FAIL wrap_data0: raddr=%0d data=%h empty=%b required 0 c0 1", s_rd_addr, pop_data, empty); end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 8'h10 + 8'(i));
    tick(1'b1, 1'b0, 1'b1, 8'h00);
    checks++; if (count !== 5'd0 || empty !== 1'b1 || pop_valid !== 1'b0 || s_rd_en !== 1'b0) begin errors++;
      $display("FAIL midreset_state: count=%0d empty=%b valid=%b rd_en=%b required 0 1 0 0", count, empty, pop_valid, s_rd_en); end
    tick(1'b0, 1'b0, 1'b1, 8'h00);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 8'h5A);
    checks++; if (s_wr_addr !== 4'd0 || s_wr_en !== 1'b1) begin errors++;
      $display("FAIL midreset_addr: addr=%0d en=%b required 0 1", s_wr_addr, s_wr_en); end
  endtask

  task automatic test_random();
    logic r, p, pp;
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(63) == 0);
      p  = ($urandom_range(99) < 55);
      pp = ($urandom_range(99) < 50);
      tick(r, p, pp, 8'($urandom));
      checks++; if (s_wr_en !== e_wr_en || s_rd_en !== e_rd_en) begin errors++;
        $display("FAIL rnd_strobes@%0d: wr=%b rd=%b required %b %b", n, s_wr_en, s_rd_en, e_wr_en, e_rd_en); end
      checks++; if ((e_wr_en && s_wr_addr !== 4'(e_wr_addr)) || (e_rd_en && s_rd_addr !== 4'(e_rd_addr))) begin errors++;
        $display("FAIL rnd_addr@%0d: waddr=%0d raddr=%0d required %0d %0d", n, s_wr_addr, s_rd_addr, e_wr_addr, e_rd_addr); end
      checks++; if (s_din !== push_data) begin errors++;
        $display("FAIL rnd_din@%0d: got %h required %h", n, s_din, push_data); end
      checks++; if (count !== 5'(q.size()) || full !== (q.size() == 16) || empty !== (q.size() == 0)) begin errors++;
        $display("FAIL rnd_count@%0d: count=%0d full=%b empty=%b required count %0d", n, count, full, empty, q.size()); end
      checks++; if (pop_valid !== exp_pv || (exp_pv && pop_data !== exp_pd)) begin errors++;
        $display("FAIL rnd_pop@%0d: valid=%b data=%h required %b %h", n, pop_valid, pop_data, exp_pv, exp_pd); end
`ifdef FIFO_ERR_FLAGS_EN
      checks++; if (overflow !== exp_ovf || underflow !== exp_unf) begin errors++;
        $display("FAIL rnd_flags@%0d: ovf=%b unf=%b required %b %b", n, overflow, underflow, exp_ovf, exp_unf); end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_fill_overflow();
    test_drain_underflow();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
